fb_line_writer: RTL and testbench

- Writer-side client of the double-buffered framebuffer controller.
- Pops line requests (two endpoints and a colour) from the line request queue and rasterises each with Bresenham.
- Emits one framebuffer pixel write (w_addr, color, en_w) per cycle.
- Generates the lineDone and lrqEmpty status the framebuffer uses to swap buffers.

---
 rtl/fb_pkg.sv | 31 +++
 rtl/bresenham_step.sv | 42 ++++
 rtl/fb_line_writer.sv | 154 +++++++++++++++
 tb/tb_fb_line_writer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer line writer.
// The optional clip feature is enabled by defining FB_WRITER_CLIP_EN.
package fb_pkg;

    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int ADDR_W  = 19;
    localparam int COLOR_W = 4;
    localparam int CW      = 12;

    typedef logic [9:0]              coord_x_t;
    typedef logic [8:0]              coord_y_t;
    typedef logic [ADDR_W-1:0]       fb_addr_t;
    typedef logic signed [CW-1:0]    cw_t;

    typedef struct packed {
        coord_x_t             x0;
        coord_y_t             y0;
        coord_x_t             x1;
        coord_y_t             y1;
        logic [COLOR_W-1:0]   color;
    } line_req_t;

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} wr_state_t;

    // Zero-extend an unsigned 10-bit coordinate into the signed datapath.
    function automatic cw_t to_cw(input logic [9:0] v);
        return cw_t'({{(CW-10){1'b0}}, v});
    endfunction

endpackage

// File: rtl/bresenham_step.sv
// One Bresenham step: next err/x/y and the matching linear framebuffer address.
module bresenham_step
    import fb_pkg::*;
(
    input  logic signed [CW-1:0] err_i,
    input  logic signed [CW-1:0] dx_i,
    input  logic signed [CW-1:0] dy_i,
    input  logic signed [CW-1:0] sx_i,
    input  logic signed [CW-1:0] sy_i,
    input  logic signed [CW-1:0] x_i,
    input  logic signed [CW-1:0] y_i,
    input  logic [ADDR_W-1:0]    addr_i,
    output logic signed [CW-1:0] err_o,
    output logic signed [CW-1:0] x_o,
    output logic signed [CW-1:0] y_o,
    output logic [ADDR_W-1:0]    addr_o
);
    localparam fb_addr_t ADDR_ONE    = fb_addr_t'(1);
    localparam fb_addr_t ADDR_STRIDE = fb_addr_t'(H_RES);

    cw_t e2;

    always_comb begin
        e2     = err_i <<< 1;
        err_o  = err_i;
        x_o    = x_i;
        y_o    = y_i;
        addr_o = addr_i;
        // Both tests use the pre-step e2, so a diagonal move applies both updates.
        if (e2 >= dy_i) begin
            err_o  = err_o + dy_i;
            x_o    = x_i + sx_i;
            addr_o = sx_i[CW-1] ? (addr_o - ADDR_ONE) : (addr_o + ADDR_ONE);
        end
        if (e2 <= dx_i) begin
            err_o  = err_o + dx_i;
            y_o    = y_i + sy_i;
            addr_o = sy_i[CW-1] ? (addr_o - ADDR_STRIDE) : (addr_o + ADDR_STRIDE);
        end
    end

endmodule

// File: rtl/fb_line_writer.sv
// Pops line requests and rasterises them into one framebuffer write per cycle.
// Define FB_WRITER_CLIP_EN to suppress writes for off-screen pixels.
module fb_line_writer
    import fb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               lrq_valid,
    input  logic [9:0]         lrq_x0,
    input  logic [8:0]         lrq_y0,
    input  logic [9:0]         lrq_x1,
    input  logic [8:0]         lrq_y1,
    input  logic [COLOR_W-1:0] lrq_color,
    output logic               lrq_pop,
    input  logic               wr_stall,
    output logic [ADDR_W-1:0]  w_addr,
    output logic [COLOR_W-1:0] color_out,
    output logic               en_w,
    output logic               lineDone,
    output logic               lrqEmpty
);
    localparam fb_addr_t ADDR_STRIDE = fb_addr_t'(H_RES);

    wr_state_t state_q, state_d;
    line_req_t req_q, req_d;
    cw_t       dx_q, dx_d, dy_q, dy_d, sx_q, sx_d, sy_q, sy_d, err_q, err_d;
    cw_t       cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    fb_addr_t  cur_addr_q, cur_addr_d;

    cw_t       x0_s, x1_s, y0_s, y1_s, diff_x, diff_y, abs_x, abs_y;
    cw_t       step_err, step_x, step_y;
    fb_addr_t  step_addr;
    logic      at_end, pix_ok;

    always_comb begin
        x0_s   = to_cw(req_q.x0);
        x1_s   = to_cw(req_q.x1);
        y0_s   = to_cw({1'b0, req_q.y0});
        y1_s   = to_cw({1'b0, req_q.y1});
        diff_x = x1_s - x0_s;
        diff_y = y1_s - y0_s;
        abs_x  = diff_x[CW-1] ? -diff_x : diff_x;
        abs_y  = diff_y[CW-1] ? -diff_y : diff_y;
        at_end = (cur_x_q == x1_s) && (cur_y_q == y1_s);
    end

    bresenham_step u_step (
        .err_i  (err_q),
        .dx_i   (dx_q),
        .dy_i   (dy_q),
        .sx_i   (sx_q),
        .sy_i   (sy_q),
        .x_i    (cur_x_q),
        .y_i    (cur_y_q),
        .addr_i (cur_addr_q),
        .err_o  (step_err),
        .x_o    (step_x),
        .y_o    (step_y),
        .addr_o (step_addr)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        err_d      = err_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        cur_addr_d = cur_addr_q;
        lrq_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (lrq_valid) begin
                    lrq_pop     = 1'b1;
                    req_d.x0    = lrq_x0;
                    req_d.y0    = lrq_y0;
                    req_d.x1    = lrq_x1;
                    req_d.y1    = lrq_y1;
                    req_d.color = lrq_color;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                dx_d       = abs_x;
                dy_d       = -abs_y;
                sx_d       = (x1_s >= x0_s) ? cw_t'(1) : -cw_t'(1);
                sy_d       = (y1_s >= y0_s) ? cw_t'(1) : -cw_t'(1);
                err_d      = abs_x - abs_y;
                cur_x_d    = x0_s;
                cur_y_d    = y0_s;
                cur_addr_d = fb_addr_t'(req_q.y0) * ADDR_STRIDE + fb_addr_t'(req_q.x0);
                state_d    = DRAW;
            end
            DRAW: begin
                if (!wr_stall) begin
                    if (at_end) begin
                        state_d = DONE;
                    end else begin
                        err_d      = step_err;
                        cur_x_d    = step_x;
                        cur_y_d    = step_y;
                        cur_addr_d = step_addr;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            err_q      <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            cur_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            err_q      <= err_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            cur_addr_q <= cur_addr_d;
        end
    end

`ifdef FB_WRITER_CLIP_EN
    localparam cw_t H_LIM = cw_t'(H_RES);
    localparam cw_t V_LIM = cw_t'(V_RES);
    assign pix_ok = (cur_x_q < H_LIM) && (cur_y_q < V_LIM);
`else
    assign pix_ok = 1'b1;
`endif

    assign en_w      = (state_q == DRAW) && !wr_stall && pix_ok;
    assign w_addr    = cur_addr_q;
    assign color_out = req_q.color;
    assign lineDone  = (state_q == DONE);
    assign lrqEmpty  = (state_q == IDLE) && !lrq_valid;

endmodule

// File: tb/tb_fb_line_writer.sv
// Directed bench for fb_line_writer with a whole-line Bresenham reference model.
module tb_fb_line_writer;

`ifdef FB_WRITER_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        lrq_valid;
    logic [9:0]  lrq_x0, lrq_x1;
    logic [8:0]  lrq_y0, lrq_y1;
    logic [3:0]  lrq_color;
    logic        lrq_pop;
    logic        wr_stall;
    logic [18:0] w_addr;
    logic [3:0]  color_out;
    logic        en_w;
    logic        lineDone;
    logic        lrqEmpty;

    fb_line_writer dut (
        .clk       (clk),
        .rst       (rst),
        .lrq_valid (lrq_valid),
        .lrq_x0    (lrq_x0),
        .lrq_y0    (lrq_y0),
        .lrq_x1    (lrq_x1),
        .lrq_y1    (lrq_y1),
        .lrq_color (lrq_color),
        .lrq_pop   (lrq_pop),
        .wr_stall  (wr_stall),
        .w_addr    (w_addr),
        .color_out (color_out),
        .en_w      (en_w),
        .lineDone  (lineDone),
        .lrqEmpty  (lrqEmpty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int color;
        bit last;
    } pix_t;

    pix_t exp_q[$];
    pix_t scratch[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pop_cnt = 0, pop_cyc = 0;
    int done_cnt = 0, done_cyc = 0;
    int line_writes = 0;
    bit done_next = 0;
    bit exp_done = 0;
    bit done_free = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s = %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Every cycle: each write must be the next pixel the model predicts.
    always @(negedge clk) begin
        pix_t p;
        if (rst) begin
            exp_done  = done_next;
            done_next = 0;
            if (lrq_pop) begin
                pop_cnt++;
                pop_cyc = cyc;
            end
            if (lineDone) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if ((lineDone || exp_done) && !done_free)
                chk("line_done", int'(lineDone), int'(exp_done));
            if (wr_stall)
                chk("stall_no_write", int'(en_w), 0);
            if (en_w) begin
                line_writes++;
                if (exp_q.size() == 0) begin
                    chk("extra_write", int'(w_addr), -1);
                end else begin
                    p = exp_q.pop_front();
                    chk("w_addr", int'(w_addr), p.addr);
                    chk("color_out", int'(color_out), p.color);
                    if (p.last) done_next = 1;
                end
            end
        end
    end

    task automatic model_line(input int x0, input int y0, input int x1, input int y1, input int c);
        int dx, dy, sx, sy, err, e2, x, y;
        bit last;
        pix_t p;
        scratch.delete();
        dx  = (x1 >= x0) ? x1 - x0 : x0 - x1;
        dy  = (y1 >= y0) ? y0 - y1 : y1 - y0;
        sx  = (x1 >= x0) ? 1 : -1;
        sy  = (y1 >= y0) ? 1 : -1;
        err = dx + dy;
        x   = x0;
        y   = y0;
        for (int k = 0; k < 4096; k++) begin
            last = (x == x1) && (y == y1);
            if (!CLIP || (x < 640 && y < 480)) begin
                p.addr  = y * 640 + x;
                p.color = c;
                p.last  = last;
                scratch.push_back(p);
            end
            if (last) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    task automatic send_line(input int x0, input int y0, input int x1, input int y1, input int c);
        bit got = 0;
        lrq_x0    = 10'(x0);
        lrq_y0    = 9'(y0);
        lrq_x1    = 10'(x1);
        lrq_y1    = 9'(y1);
        lrq_color = 4'(c);
        lrq_valid = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (lrq_pop) got = 1;
        end
        if (!got) chk("pop_timeout", 0, 1);
        else      chk("lrq_empty_busy", int'(lrqEmpty), 0);
        @(posedge clk);
        #1;
        lrq_valid = 1'b0;
        lrq_x0    = 10'($urandom);
        lrq_x1    = 10'($urandom);
        lrq_y0    = 9'($urandom);
        lrq_y1    = 9'($urandom);
        lrq_color = 4'($urandom);
    endtask

    task automatic start_line(input int x0, input int y0, input int x1, input int y1, input int c);
        model_line(x0, y0, x1, y1, c);
        foreach (scratch[i]) exp_q.push_back(scratch[i]);
        send_line(x0, y0, x1, y1, c);
    endtask

    task automatic wait_done(input int target);
        bit got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk);
            if (done_cnt >= target) got = 1;
        end
        if (!got) chk("done_timeout", done_cnt, target);
        #1;
    endtask

    // Waits for the line, then checks pop->lineDone latency, write count and pop count.
    task automatic finish_line(input string name, input int d0, input int w0, input int p0,
                               input int exp_lat, input int exp_writes);
        wait_done(d0 + 1);
        chk({name, "_latency"}, done_cyc - pop_cyc, exp_lat);
        chk({name, "_writes"}, line_writes - w0, exp_writes);
        chk({name, "_pops"}, pop_cnt - p0, 1);
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int d0, w0, p0, pop1;
        rst       = 1'b0;
        lrq_valid = 1'b0;
        wr_stall  = 1'b0;
        lrq_x0 = '0; lrq_y0 = '0; lrq_x1 = '0; lrq_y1 = '0; lrq_color = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en_w", int'(en_w), 0);
        chk("rst_lineDone", int'(lineDone), 0);
        chk("rst_lrq_pop", int'(lrq_pop), 0);
        chk("rst_w_addr", int'(w_addr), 0);
        chk("rst_color_out", int'(color_out), 0);
        chk("rst_lrqEmpty", int'(lrqEmpty), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Horizontal (0,0)->(3,0), colour 5
        d0 = done_cnt; w0 = line_writes; p0 = pop_cnt;
        start_line(0, 0, 3, 0, 5);
        chk("model_h_len", scratch.size(), 4);
        chk("model_h3", scratch[3].addr, 3);
        finish_line("horiz", d0, w0, p0, 6, 4);

        // Vertical (10,2)->(10,4)
        d0 = done_cnt; w0 = line_writes; p0 = pop_cnt;
        start_line(10, 2, 10, 4, 9);
        chk("model_v0", scratch[0].addr, 1290);
        chk("model_v1", scratch[1].addr, 1930);
        chk("model_v2", scratch[2].addr, 2570);
        finish_line("vert", d0, w0, p0, 5, 3);
        repeat (3) @(posedge clk);
        #1;
        chk("vert_single_pop", pop_cnt - p0, 1);

        // Reversed diagonal (3,3)->(0,0)
        d0 = done_cnt; w0 = line_writes; p0 = pop_cnt;
        start_line(3, 3, 0, 0, 12);
        chk("model_d0", scratch[0].addr, 1923);
        chk("model_d1", scratch[1].addr, 1282);
        chk("model_d2", scratch[2].addr, 641);
        chk("model_d3", scratch[3].addr, 0);
        finish_line("diag", d0, w0, p0, 6, 4);
        @(negedge clk);
        chk("idle_lrqEmpty", int'(lrqEmpty), 1);
        @(posedge clk);
        #1;

        // Single point at the far corner
        d0 = done_cnt; w0 = line_writes; p0 = pop_cnt;
        start_line(639, 479, 639, 479, 15);
        chk("model_pt", scratch[0].addr, 307199);
        finish_line("point", d0, w0, p0, 3, 1);

        // Stall held 3 cycles mid-line on (0,0)->(5,0)
        d0 = done_cnt; w0 = line_writes; p0 = pop_cnt;
        start_line(0, 0, 5, 0, 3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        wr_stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        wr_stall = 1'b0;
        finish_line("stall", d0, w0, p0, 11, 6);

        // Back-to-back lines: second pop comes n1+3 cycles after the first
        d0 = done_cnt; w0 = line_writes;
        start_line(0, 0, 2, 2, 6);
        pop1 = pop_cyc;
        start_line(5, 1, 7, 1, 10);
        chk("b2b_pop_gap", pop_cyc - pop1, 6);
        wait_done(d0 + 2);
        chk("b2b_latency", done_cyc - pop_cyc, 5);
        chk("b2b_writes", line_writes - w0, 6);

        // Asynchronous reset in the middle of a long line
        d0 = done_cnt;
        start_line(0, 0, 100, 0, 7);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_en_w", int'(en_w), 0);
        exp_q.delete();
        done_next = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_lrqEmpty", int'(lrqEmpty), 1);
        chk("post_rst_no_done", done_cnt - d0, 0);
        @(posedge clk);
        #1;

`ifdef FB_WRITER_CLIP_EN
        // Line running off the right edge: only on-screen pixels are written
        d0 = done_cnt; w0 = line_writes; p0 = pop_cnt;
        done_free = 1;
        start_line(637, 0, 642, 0, 2);
        chk("model_clip_len", scratch.size(), 3);
        chk("model_clip2", scratch[2].addr, 639);
        finish_line("clip", d0, w0, p0, 8, 3);
        done_free = 0;
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
